// File: rtl/rx78_cart_loader.sv
// RX-78 cartridge loader: streams an HPS download into cartridge BRAM, pads the
// unused tail with FILL_BYTE and then serves CPU accesses through the same port.
module rx78_cart_loader #(
    parameter logic [7:0] CART_INDEX = 8'd1,
    parameter logic [7:0] FILL_BYTE  = 8'hFF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [14:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_ack,
    output logic [14:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    input  logic [7:0]  ram_dout,
    output logic        cpu_hold,
    output logic        cart_valid,
    output logic [15:0] cart_size,
    output logic        cart_ovf
);

    typedef enum logic [1:0] {IDLE, LOAD, FILL, READY} state_t;

    state_t      state_q, state_d;
    logic [14:0] fillAddr_q, fillAddr_d;
    logic [15:0] cartSize_q, cartSize_d;
    logic        cartOvf_q, cartOvf_d;
    logic        cartValid_q, cartValid_d;
    logic        bufValid_q, bufValid_d;
    logic [14:0] bufAddr_q, bufAddr_d;
    logic [7:0]  bufData_q, bufData_d;
    logic [14:0] ramAddr_q, ramAddr_d;
    logic [7:0]  ramDin_q, ramDin_d;
    logic        ramWe_q, ramWe_d;
    logic        s1Valid_q, s1Valid_d;
    logic        s1We_q, s1We_d;
    logic        s1Idle_q, s1Idle_d;
    logic        s2Valid_q, s2Valid_d;
    logic        s2Read_q, s2Read_d;
    logic        s2Idle_q, s2Idle_d;

    logic        dlActive;
    logic        enterLoad;
    logic        wrAccept;
    logic        wrInRange;
    logic [15:0] newSize;
    logic [15:0] sizeBase;

    // A qualifying download in any non-LOAD state means we are (re)entering LOAD.
    assign dlActive  = ioctl_download && (ioctl_index == CART_INDEX);
    assign enterLoad = dlActive && (state_q != LOAD);
    assign wrAccept  = ioctl_wr && dlActive && !bufValid_q;
    assign wrInRange = (ioctl_addr[24:15] == 10'd0);
    assign newSize   = {1'b0, ioctl_addr[14:0]} + 16'd1;
    assign sizeBase  = enterLoad ? 16'd0 : cartSize_q;

    always_comb begin
        state_d     = state_q;
        fillAddr_d  = fillAddr_q;
        cartSize_d  = cartSize_q;
        cartOvf_d   = cartOvf_q;
        cartValid_d = cartValid_q;
        bufValid_d  = bufValid_q;
        bufAddr_d   = bufAddr_q;
        bufData_d   = bufData_q;
        ramAddr_d   = ramAddr_q;
        ramDin_d    = ramDin_q;
        ramWe_d     = 1'b0;
        s1Valid_d   = 1'b0;
        s1We_d      = s1We_q;
        s1Idle_d    = s1Idle_q;
        s2Valid_d   = s1Valid_q;
        s2Read_d    = s1Valid_q && !s1We_q;
        s2Idle_d    = s1Idle_q;

        case (state_q)
            IDLE, READY, FILL: begin
                if (dlActive) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (!dlActive) begin
                    if (cartSize_q == 16'h8000) begin
                        state_d     = READY;
                        cartValid_d = 1'b1;
                    end else begin
                        state_d    = FILL;
                        fillAddr_d = cartSize_q[14:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (enterLoad) begin
            cartValid_d = 1'b0;
            cartSize_d  = 16'd0;
            cartOvf_d   = 1'b0;
        end

        // A download byte colliding with an in-flight CPU access waits in the buffer.
        if (wrAccept) begin
            if (wrInRange) begin
                if (newSize > sizeBase) begin
                    cartSize_d = newSize;
                end
                if (s1Valid_q) begin
                    bufValid_d = 1'b1;
                    bufAddr_d  = ioctl_addr[14:0];
                    bufData_d  = ioctl_dout;
                end else begin
                    ramWe_d   = 1'b1;
                    ramAddr_d = ioctl_addr[14:0];
                    ramDin_d  = ioctl_dout;
                end
            end else begin
                cartOvf_d = 1'b1;
            end
        end

        if (bufValid_q && !s1Valid_q) begin
            ramWe_d    = 1'b1;
            ramAddr_d  = bufAddr_q;
            ramDin_d   = bufData_q;
            bufValid_d = 1'b0;
        end

        if ((state_q == FILL) && !dlActive && !bufValid_q) begin
            ramWe_d   = 1'b1;
            ramAddr_d = fillAddr_q;
            ramDin_d  = FILL_BYTE;
            if (fillAddr_q == 15'h7FFF) begin
                state_d     = READY;
                cartValid_d = 1'b1;
            end else begin
                fillAddr_d = fillAddr_q + 15'd1;
            end
        end

        // CPU is served only when nothing else wants the port and no access is pending.
        if (cpu_req && ((state_q == IDLE) || (state_q == READY)) && !dlActive
            && !bufValid_q && !s1Valid_q && !s2Valid_q) begin
            s1Valid_d = 1'b1;
            s1We_d    = cpu_we;
            s1Idle_d  = (state_q == IDLE);
            ramAddr_d = cpu_addr;
            ramDin_d  = cpu_din;
            ramWe_d   = cpu_we && (state_q == READY);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            fillAddr_q  <= 15'd0;
            cartSize_q  <= 16'd0;
            cartOvf_q   <= 1'b0;
            cartValid_q <= 1'b0;
            bufValid_q  <= 1'b0;
            bufAddr_q   <= 15'd0;
            bufData_q   <= 8'd0;
            ramAddr_q   <= 15'd0;
            ramDin_q    <= 8'd0;
            ramWe_q     <= 1'b0;
            s1Valid_q   <= 1'b0;
            s1We_q      <= 1'b0;
            s1Idle_q    <= 1'b0;
            s2Valid_q   <= 1'b0;
            s2Read_q    <= 1'b0;
            s2Idle_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            fillAddr_q  <= fillAddr_d;
            cartSize_q  <= cartSize_d;
            cartOvf_q   <= cartOvf_d;
            cartValid_q <= cartValid_d;
            bufValid_q  <= bufValid_d;
            bufAddr_q   <= bufAddr_d;
            bufData_q   <= bufData_d;
            ramAddr_q   <= ramAddr_d;
            ramDin_q    <= ramDin_d;
            ramWe_q     <= ramWe_d;
            s1Valid_q   <= s1Valid_d;
            s1We_q      <= s1We_d;
            s1Idle_q    <= s1Idle_d;
            s2Valid_q   <= s2Valid_d;
            s2Read_q    <= s2Read_d;
            s2Idle_q    <= s2Idle_d;
        end
    end

    // Read data comes straight from the BRAM output in the ack cycle.
    assign cpu_dout   = (s2Valid_q && s2Read_q) ? (s2Idle_q ? FILL_BYTE : ram_dout) : 8'h00;
    assign cpu_ack    = s2Valid_q;
    assign ioctl_wait = bufValid_q;
    assign ram_addr   = ramAddr_q;
    assign ram_din    = ramDin_q;
    assign ram_we     = ramWe_q;
    assign cpu_hold   = (state_q == LOAD) || (state_q == FILL);
    assign cart_valid = cartValid_q;
    assign cart_size  = cartSize_q;
    assign cart_ovf   = cartOvf_q;

endmodule

// File: doc/rx78_cart_loader.md
RX78_CART_LOADER -- requirements
Module: rx78_cart_loader

Interface
REQ-001 SHALL have parameter CART_INDEX, default 8'd1, ioctl_index value selecting cartridge download.
REQ-002 SHALL have parameter FILL_BYTE, default 8'hFF, value written to unloaded cartridge space.
REQ-003 SHALL have port clk_sys  in  1  single clock for all logic; every port is synchronous to it.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports ioctl_download in 1, ioctl_index in 8, ioctl_wr in 1, ioctl_addr in 25, ioctl_dout in 8: HPS download stream.
REQ-006 SHALL have port ioctl_wait  out  1  stall request to HPS.
REQ-007 SHALL have ports cpu_req in 1, cpu_we in 1, cpu_addr in 15, cpu_din in 8: CPU cartridge access.
REQ-008 SHALL have ports cpu_dout out 8, cpu_ack out 1: read data and one-cycle completion pulse.
REQ-009 SHALL have ports ram_addr out 15, ram_din out 8, ram_we out 1, ram_dout in 8: single-port cartridge BRAM with 1-cycle read latency.
REQ-010 SHALL have ports cpu_hold out 1 (hold CPU in reset), cart_valid out 1, cart_size out 16, cart_ovf out 1.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, FILL, READY.
REQ-012 IDLE->LOAD when ioctl_download=1 and ioctl_index=CART_INDEX; on entry clear cart_valid, cart_size, cart_ovf.
REQ-013 Downloads with any other ioctl_index SHALL be ignored in every state.
REQ-014 In LOAD each ioctl_wr with ioctl_addr<32768 SHALL write ioctl_dout to ram_addr=ioctl_addr[14:0] with ram_we=1 in the following cycle.
REQ-015 In LOAD each ioctl_wr with ioctl_addr>=32768 SHALL not write RAM and SHALL set cart_ovf=1.
REQ-016 cart_size SHALL track max(accepted ioctl_addr)+1, saturating at 16'h8000.
REQ-017 LOAD->FILL on ioctl_download falling; FILL SHALL write FILL_BYTE to addresses cart_size..0x7FFF, one per cycle, ascending.
REQ-018 FILL->READY after writing 0x7FFF, or immediately when cart_size=0x8000; entering READY sets cart_valid=1.
REQ-019 cpu_hold SHALL be 1 in LOAD and FILL, 0 in IDLE and READY.
REQ-020 READY->LOAD on a new qualifying download start (REQ-012); a qualifying start during FILL SHALL abort FILL and enter LOAD.
REQ-021 In IDLE/READY a cpu_req granted in cycle T SHALL drive ram_addr=cpu_addr in T+1; reads SHALL give cpu_dout=ram_dout and cpu_ack=1 in T+2; writes (cpu_we=1) assert ram_we in T+1 and cpu_ack in T+2.
REQ-022 cpu_req SHALL be held by requester until cpu_ack; a new request SHALL not be granted before the ack cycle.
REQ-023 Arbitration: download writes have priority over CPU; ioctl_wr arriving while a CPU access is in flight SHALL be stored in a one-entry buffer and written after it.
REQ-024 ioctl_wait SHALL be 1 while the buffer is occupied, so no ioctl_wr is ever lost.
REQ-025 CPU write requests in IDLE SHALL be acked without writing RAM; CPU reads in IDLE return FILL_BYTE.
REQ-026 ram_we SHALL be 0 in every cycle without a scheduled write; at most one RAM access per cycle.

Reset
REQ-027 On reset: state IDLE, cpu_hold=0, cart_valid=0, cart_size=0, cart_ovf=0, ioctl_wait=0, cpu_ack=0, cpu_dout=0, ram_we=0, ram_addr=0, buffer empty.
REQ-028 Reset mid-LOAD or mid-FILL SHALL abort immediately with no further RAM writes.

Verification
REQ-029 Download index 1, 16 bytes 0x00..0x0F at addr 0..15 -> RAM[0..15] match, RAM[16..0x7FFF]=0xFF, cart_size=16, cart_valid=1, cpu_hold low after 32752 fill cycles.
REQ-030 Download index 2 -> no RAM writes, state unchanged, cpu_hold stays 0.
REQ-031 Download 40000 bytes -> cart_ovf=1, cart_size=0x8000, no FILL cycles, RAM[0x7FFF]=byte 32767.
REQ-032 READY, cpu_req read of 0x0005 in T -> cpu_ack=1 and cpu_dout=RAM[5] in T+2; ioctl_wr in T+1 -> ioctl_wait=1 for one cycle, write completes.
REQ-033 Reset asserted at FILL address 0x1000 -> ram_we drops same cycle, state IDLE, cart_valid=0.
REQ-034 New index-1 download during FILL -> FILL aborted, LOAD entered, cart_size restarts from 0.
